// File: rtl/cpu_seq_ctl.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with halt/err traps and perf counters.
// Latency: 4 cycles per non-memory instruction, 5 with a memory access; all outputs registered (Moore).
// Backpressure: FETCH/MEM hold their request until ack, bounded by MEM_TIMEOUT; i_run gates IDLE exit and WB continuation.
module cpu_seq_ctl #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst_n,
    input  logic                 i_run,
    input  logic                 i_ifu_ack,
    input  logic                 i_lsu_ack,
    input  logic                 i_idu_end_flag,
    input  logic                 i_idu_ram_rd,
    input  logic                 i_idu_ram_wr_en,
    input  logic                 i_idu_reg_wr_en,
    output logic                 o_ifu_req,
    output logic                 o_idu_ready,
    output logic                 o_exu_ready,
    output logic                 o_lsu_req,
    output logic                 o_gpr_wr_en,
    output logic                 o_pc_upd_en,
    output logic [2:0]           o_state,
    output logic                 o_halt,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_cyc_cnt,
    output logic [CNT_WIDTH-1:0] o_ret_cnt
);

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_nxt;
    logic                  r_mem_op;
    logic                  r_reg_wr;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  w_to_hit;
    logic                  w_active;
    logic                  r_ifu_req;
    logic                  r_idu_ready;
    logic                  r_exu_ready;
    logic                  r_lsu_req;
    logic                  r_gpr_wr_en;
    logic                  r_pc_upd_en;
    logic                  r_halt;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cyc_cnt;
    logic [CNT_WIDTH-1:0]  r_ret_cnt;

    // Fires on the wait cycle whose increment would reach the limit; an ack in that cycle still wins.
    assign w_to_hit = (MEM_TIMEOUT != 0) &&
                      ((32'(r_to_cnt) + 32'd1) == 32'(MEM_TIMEOUT));

    assign w_active = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_run) w_nxt = S_FETCH;
            S_FETCH: begin
                if (i_ifu_ack)     w_nxt = S_DECODE;
                else if (w_to_hit) w_nxt = S_ERR;
            end
            S_DECODE: w_nxt = i_idu_end_flag ? S_HALT : S_EXEC;
            S_EXEC:   w_nxt = r_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (i_lsu_ack)     w_nxt = S_WB;
                else if (w_to_hit) w_nxt = S_ERR;
            end
            S_WB:     w_nxt = i_run ? S_FETCH : S_IDLE;
            S_HALT:   w_nxt = S_HALT;
            S_ERR:    w_nxt = S_ERR;
            default:  w_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with o_state exactly.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state     <= S_IDLE;
            r_mem_op    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_to_cnt    <= '0;
            r_ifu_req   <= 1'b0;
            r_idu_ready <= 1'b0;
            r_exu_ready <= 1'b0;
            r_lsu_req   <= 1'b0;
            r_gpr_wr_en <= 1'b0;
            r_pc_upd_en <= 1'b0;
            r_halt      <= 1'b0;
            r_err       <= 1'b0;
            r_cyc_cnt   <= '0;
            r_ret_cnt   <= '0;
        end else begin
            r_state <= w_nxt;

            if (r_state == S_DECODE) begin
                r_mem_op <= i_idu_ram_rd | i_idu_ram_wr_en;
                r_reg_wr <= i_idu_reg_wr_en;
            end

            // FETCH and MEM are never adjacent, so clearing outside them gives a fresh count on each entry.
            if (r_state == S_FETCH || r_state == S_MEM)
                r_to_cnt <= r_to_cnt + TO_W'(1);
            else
                r_to_cnt <= '0;

            r_ifu_req   <= (w_nxt == S_FETCH);
            r_idu_ready <= (w_nxt == S_DECODE);
            r_exu_ready <= (w_nxt == S_EXEC);
            r_lsu_req   <= (w_nxt == S_MEM);
            r_pc_upd_en <= (w_nxt == S_WB);
            r_gpr_wr_en <= (w_nxt == S_WB) && r_reg_wr;
            r_halt      <= (w_nxt == S_HALT);
            r_err       <= (w_nxt == S_ERR);

            if (w_active && (r_cyc_cnt != '1))
                r_cyc_cnt <= r_cyc_cnt + CNT_WIDTH'(1);
            if ((r_state == S_WB) && (r_ret_cnt != '1))
                r_ret_cnt <= r_ret_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_ifu_req   = r_ifu_req;
    assign o_idu_ready = r_idu_ready;
    assign o_exu_ready = r_exu_ready;
    assign o_lsu_req   = r_lsu_req;
    assign o_gpr_wr_en = r_gpr_wr_en;
    assign o_pc_upd_en = r_pc_upd_en;
    assign o_state     = r_state;
    assign o_halt      = r_halt;
    assign o_err       = r_err;
    assign o_cyc_cnt   = r_cyc_cnt;
    assign o_ret_cnt   = r_ret_cnt;

endmodule

// File: tb/tb_cpu_seq_ctl.sv
// Bench for cpu_seq_ctl: expected per-cycle state traces are built from instruction descriptions
// (kind, ack delays, run control) and compared cycle by cycle, with randomized don't-care inputs.
module tb_cpu_seq_ctl;

    localparam int CW   = 4;
    localparam int TO   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          i_sys_clk = 1'b0;
    logic          i_sys_rst_n;
    logic          i_run;
    logic          i_ifu_ack;
    logic          i_lsu_ack;
    logic          i_idu_end_flag;
    logic          i_idu_ram_rd;
    logic          i_idu_ram_wr_en;
    logic          i_idu_reg_wr_en;
    logic          o_ifu_req;
    logic          o_idu_ready;
    logic          o_exu_ready;
    logic          o_lsu_req;
    logic          o_gpr_wr_en;
    logic          o_pc_upd_en;
    logic [2:0]    o_state;
    logic          o_halt;
    logic          o_err;
    logic [CW-1:0] o_cyc_cnt;
    logic [CW-1:0] o_ret_cnt;

    cpu_seq_ctl #(.CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
        .i_sys_clk       (i_sys_clk),
        .i_sys_rst_n     (i_sys_rst_n),
        .i_run           (i_run),
        .i_ifu_ack       (i_ifu_ack),
        .i_lsu_ack       (i_lsu_ack),
        .i_idu_end_flag  (i_idu_end_flag),
        .i_idu_ram_rd    (i_idu_ram_rd),
        .i_idu_ram_wr_en (i_idu_ram_wr_en),
        .i_idu_reg_wr_en (i_idu_reg_wr_en),
        .o_ifu_req       (o_ifu_req),
        .o_idu_ready     (o_idu_ready),
        .o_exu_ready     (o_exu_ready),
        .o_lsu_req       (o_lsu_req),
        .o_gpr_wr_en     (o_gpr_wr_en),
        .o_pc_upd_en     (o_pc_upd_en),
        .o_state         (o_state),
        .o_halt          (o_halt),
        .o_err           (o_err),
        .o_cyc_cnt       (o_cyc_cnt),
        .o_ret_cnt       (o_ret_cnt)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int n_chk = 0;
    int n_bad = 0;
    int m_cyc = 0;
    int m_ret = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic step();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic noise();
        i_run           = 1'($urandom);
        i_ifu_ack       = 1'($urandom);
        i_lsu_ack       = 1'($urandom);
        i_idu_end_flag  = 1'($urandom);
        i_idu_ram_rd    = 1'($urandom);
        i_idu_ram_wr_en = 1'($urandom);
        i_idu_reg_wr_en = 1'($urandom);
    endtask

    // Strobe order: ifu_req idu_ready exu_ready lsu_req gpr_wr pc_upd halt err
    task automatic expect_st(input int st, input bit gpr);
        logic [7:0] e;
        e = {st == 1, st == 2, st == 3, st == 4, (st == 5) && gpr, st == 5, st == 6, st == 7};
        chk("state", 32'(o_state), 32'(st));
        chk("strobes", 32'({o_ifu_req, o_idu_ready, o_exu_ready, o_lsu_req,
                            o_gpr_wr_en, o_pc_upd_en, o_halt, o_err}), 32'(e));
        chk("cyc_cnt", 32'(o_cyc_cnt), 32'(sat(m_cyc)));
        chk("ret_cnt", 32'(o_ret_cnt), 32'(sat(m_ret)));
        if (st >= 1 && st <= 5) m_cyc++;
        if (st == 5) m_ret++;
    endtask

    task automatic err_tail();
        for (int k = 0; k < 3; k++) begin
            noise();
            expect_st(7, 1'b0);
            step();
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            noise();
            i_run = (k == n - 1);
            expect_st(0, 1'b0);
            step();
        end
    endtask

    task automatic do_reset();
        i_sys_rst_n     = 1'b0;
        i_run           = 1'b0;
        i_ifu_ack       = 1'b0;
        i_lsu_ack       = 1'b0;
        i_idu_end_flag  = 1'b0;
        i_idu_ram_rd    = 1'b0;
        i_idu_ram_wr_en = 1'b0;
        i_idu_reg_wr_en = 1'b0;
        #1;
        m_cyc = 0;
        m_ret = 0;
        expect_st(0, 1'b0);
        #1;
        i_sys_rst_n = 1'b1;
        step();
    endtask

    // kind: 0 alu/branch, 1 load, 2 store, 3 end. A delay >= TO means the ack never arrives in time.
    task automatic instr(input int kind, input int fd, input int md, input bit rw, input bit run_next);
        for (int i = 0; i <= fd; i++) begin
            if (i == TO) begin
                err_tail();
                return;
            end
            noise();
            i_ifu_ack = (i == fd);
            expect_st(1, 1'b0);
            step();
        end
        noise();
        i_idu_end_flag  = (kind == 3);
        i_idu_ram_rd    = (kind == 1);
        i_idu_ram_wr_en = (kind == 2);
        i_idu_reg_wr_en = rw;
        expect_st(2, 1'b0);
        step();
        if (kind == 3) begin
            for (int k = 0; k < 4; k++) begin
                noise();
                expect_st(6, 1'b0);
                step();
            end
            return;
        end
        noise();
        expect_st(3, 1'b0);
        step();
        if (kind == 1 || kind == 2) begin
            for (int j = 0; j <= md; j++) begin
                if (j == TO) begin
                    err_tail();
                    return;
                end
                noise();
                i_lsu_ack = (j == md);
                expect_st(4, 1'b0);
                step();
            end
        end
        noise();
        i_run = run_next;
        expect_st(5, rw);
        step();
    endtask

    initial begin
        i_sys_rst_n = 1'b0;
        noise();
        step();
        do_reset();

        idle(2);
        instr(0, 0, 0, 1'b1, 1'b1);   // ALU: 1,2,3,5 then FETCH with cyc=4 ret=1
        instr(1, 0, 3, 1'b1, 1'b1);   // load, MEM held 4 cycles
        instr(2, 1, 0, 1'b0, 1'b0);   // store, run dropped -> IDLE
        idle(3);                      // cyc frozen while idle
        instr(0, 3, 0, 1'b0, 1'b1);   // ack in last allowed FETCH cycle wins

        for (int n = 0; n < 30; n++) begin
            int  kind;
            bit  rw;
            bit  rn;
            kind = $urandom_range(0, 2);
            rw   = (kind == 2) ? 1'b0 : 1'($urandom);
            rn   = ($urandom_range(0, 3) != 0);
            instr(kind, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), rw, rn);
            if (!rn) idle($urandom_range(1, 3));
        end
        instr(3, 1, 0, 1'b0, 1'b1);   // end instruction -> HALT, sticky
        do_reset();

        idle(1);
        instr(0, TO, 0, 1'b1, 1'b1);  // fetch timeout -> ERR
        do_reset();

        idle(1);
        instr(1, 0, TO + 2, 1'b1, 1'b1);  // memory timeout -> ERR
        do_reset();

        idle(2);
        noise(); i_ifu_ack = 1'b1; expect_st(1, 1'b0); step();
        noise(); i_idu_end_flag = 1'b0; i_idu_ram_rd = 1'b1; i_idu_ram_wr_en = 1'b0;
        expect_st(2, 1'b0); step();
        noise(); expect_st(3, 1'b0); step();
        noise(); i_lsu_ack = 1'b0; expect_st(4, 1'b0); step();
        do_reset();                   // reset mid-MEM clears request and counters at once
        idle(1);
        instr(0, 0, 0, 1'b1, 1'b0);
        idle(1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
